// File: rtl/ni_tx_pkg.sv
// Shared flit format for the NI injector: type codes, field positions, FSM states.
// The router input channel decodes flits with these same constants.
package ni_tx_pkg;

  localparam int DATAW = 64;
  localparam int NODEW = 4;
  localparam int NVCH  = 2;
  localparam int LENW  = 4;
  localparam int VCW   = (NVCH > 1) ? $clog2(NVCH) : 1;
  localparam int PAYW  = DATAW - 3;

  // Head flit layout, MSB first: TYPE | DST | SRC | VCH | zero fill
  localparam int TYPE_MSB = DATAW - 1;
  localparam int TYPE_LSB = DATAW - 3;
  localparam int DST_MSB  = TYPE_LSB - 1;
  localparam int DST_LSB  = DST_MSB - NODEW + 1;
  localparam int SRC_MSB  = DST_LSB - 1;
  localparam int SRC_LSB  = SRC_MSB - NODEW + 1;
  localparam int VCH_MSB  = SRC_LSB - 1;
  localparam int VCH_LSB  = VCH_MSB - VCW + 1;

  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

  typedef enum logic [2:0] {
    TYPE_NONE     = 3'd0,
    TYPE_HEAD     = 3'd1,
    TYPE_BODY     = 3'd2,
    TYPE_TAIL     = 3'd3,
    TYPE_HEADTAIL = 3'd4
  } flit_type_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_VCSEL = 2'd1,
    S_HEAD  = 2'd2,
    S_BODY  = 2'd3
  } state_e;

  function automatic logic [DATAW-1:0] head_flit(flit_type_e t, logic [NODEW-1:0] dst,
                                                 logic [NODEW-1:0] src, logic [VCW-1:0] vc);
    logic [DATAW-1:0] f;
    f = '0;
    f[TYPE_MSB:TYPE_LSB] = t;
    f[DST_MSB:DST_LSB]   = dst;
    f[SRC_MSB:SRC_LSB]   = src;
    f[VCH_MSB:VCH_LSB]   = vc;
    return f;
  endfunction

endpackage

// File: rtl/ni_tx_if.sv
// Core send port plus router link for one NI injector.
// master = the injector, slave = core/router side.
interface ni_tx_if;
  import ni_tx_pkg::*;

  logic                 pkt_valid;
  logic                 pkt_ready;
  logic [NODEW-1:0]     pkt_dst;
  logic [LENW-1:0]      pkt_len;
  logic                 pay_valid;
  logic                 pay_ready;
  logic [PAYW-1:0]      pay_data;
  logic [DATAW-1:0]     odata;
  logic                 ovalid;
  logic [VCW-1:0]       ovch;
  logic [NVCH-1:0]      irdy;
  logic [NVCH-1:0]      ilck;

  modport master (
    input  pkt_valid, pkt_dst, pkt_len, pay_valid, pay_data, irdy, ilck,
    output pkt_ready, pay_ready, odata, ovalid, ovch
  );

  modport slave (
    output pkt_valid, pkt_dst, pkt_len, pay_valid, pay_data, irdy, ilck,
    input  pkt_ready, pay_ready, odata, ovalid, ovch
  );

endinterface

// File: rtl/ni_vcsel.sv
// Round-robin free-VC picker: first VC at or after rr_ptr that is unlocked and ready.
module ni_vcsel
  import ni_tx_pkg::*;
(
  input  logic [NVCH-1:0] ilck,
  input  logic [NVCH-1:0] irdy,
  input  logic [VCW-1:0]  rr_ptr,
  output logic [VCW-1:0]  grant,
  output logic            valid
);

  logic [VCW:0]   sum;
  logic [VCW-1:0] idx;

  // Scan from the farthest offset down so the closest eligible VC wins.
  always_comb begin
    valid = 1'b0;
    grant = '0;
    sum   = '0;
    idx   = '0;
    for (int i = NVCH - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (VCW+1)'(i);
      if (sum >= (VCW+1)'(NVCH)) sum = sum - (VCW+1)'(NVCH);
      idx = sum[VCW-1:0];
      if (!ilck[idx] && irdy[idx]) begin
        valid = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/ni_tx.sv
// NI injector: takes a descriptor + payload stream from the core and drives
// head/body/tail flits onto the local router input channel, honouring per-VC ready/lock.
module ni_tx
  import ni_tx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_,
  input  logic [NODEW-1:0] my_id,
  ni_tx_if.master          link,
  output logic             busy,
  output logic [15:0]      tx_pkts
);

  state_e           state, nstate;
  logic [NODEW-1:0] dst_q;
  logic [LENW-1:0]  len_q, rem_q;
  logic [VCW-1:0]   cur_vc, rr_ptr, grant;
  logic             gnt_vld;
  logic             pkt_acc, head_go, body_go, last;

  ni_vcsel u_vcsel (
    .ilck   (link.ilck),
    .irdy   (link.irdy),
    .rr_ptr (rr_ptr),
    .grant  (grant),
    .valid  (gnt_vld)
  );

  assign pkt_acc = (state == S_IDLE) && link.pkt_valid;
  assign head_go = (state == S_HEAD) && link.irdy[cur_vc];
  assign body_go = (state == S_BODY) && link.irdy[cur_vc] && link.pay_valid;
  assign last    = (rem_q == LENW'(1));

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) state <= S_IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  if (pkt_acc) nstate = S_VCSEL;
      S_VCSEL: if (gnt_vld) nstate = S_HEAD;
      S_HEAD:  if (head_go) nstate = (len_q == '0) ? S_IDLE : S_BODY;
      S_BODY:  if (body_go && last) nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_comb begin
    link.pkt_ready = Disable;
    link.pay_ready = Disable;
    busy           = Enable;
    case (state)
      S_IDLE: begin
        link.pkt_ready = Enable;
        busy           = Disable;
      end
      S_BODY:  link.pay_ready = link.irdy[cur_vc];
      default: ;
    endcase
  end

  // Link outputs are registered and fall back to all-zero whenever nothing issues.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      dst_q       <= '0;
      len_q       <= '0;
      rem_q       <= '0;
      cur_vc      <= '0;
      rr_ptr      <= '0;
      tx_pkts     <= '0;
      link.odata  <= '0;
      link.ovalid <= 1'b0;
      link.ovch   <= '0;
    end else begin
      link.odata  <= '0;
      link.ovalid <= 1'b0;
      link.ovch   <= '0;
      if (pkt_acc) begin
        dst_q <= link.pkt_dst;
        len_q <= link.pkt_len;
      end
      if (state == S_VCSEL && gnt_vld) cur_vc <= grant;
      if (head_go) begin
        link.odata  <= head_flit((len_q == '0) ? TYPE_HEADTAIL : TYPE_HEAD, dst_q, my_id, cur_vc);
        link.ovalid <= 1'b1;
        link.ovch   <= cur_vc;
        rem_q       <= len_q;
        rr_ptr      <= (cur_vc == VCW'(NVCH - 1)) ? '0 : cur_vc + VCW'(1);
      end
      if (body_go) begin
        link.odata  <= {last ? TYPE_TAIL : TYPE_BODY, link.pay_data};
        link.ovalid <= 1'b1;
        link.ovch   <= cur_vc;
        rem_q       <= rem_q - LENW'(1);
      end
      if ((head_go && len_q == '0) || (body_go && last)) tx_pkts <= tx_pkts + 16'd1;
    end
  end

endmodule

// File: tb/tb_ni_tx.sv
// Directed bench for ni_tx: head/body/tail framing, VC round-robin, backpressure,
// mid-packet reset and packet-counter wrap.
module tb_ni_tx;
  import ni_tx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ = 1'b1;
  logic [3:0]  my_id;
  logic        busy;
  logic [15:0] tx_pkts;
  int          checks = 0;
  int          errors = 0;

  ni_tx_if bus ();

  ni_tx dut (
    .clk     (clk),
    .rst_    (rst_),
    .my_id   (my_id),
    .link    (bus.master),
    .busy    (busy),
    .tx_pkts (tx_pkts)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk_head(logic [2:0] t, logic [3:0] d, logic [3:0] s, logic v);
    return {t, d, s, v, 52'b0};
  endfunction

  function automatic logic [63:0] mk_pay(logic [2:0] t, logic [60:0] p);
    return {t, p};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves us just after the accepting edge; two more steps put the head on the link.
  task automatic send_desc(input logic [3:0] d, input logic [3:0] l);
    bus.pkt_dst   = d;
    bus.pkt_len   = l;
    bus.pkt_valid = 1'b1;
    step();
    bus.pkt_valid = 1'b0;
  endtask

  initial begin
    my_id         = 4'd2;
    bus.pkt_valid = 1'b0;
    bus.pkt_dst   = '0;
    bus.pkt_len   = '0;
    bus.pay_valid = 1'b0;
    bus.pay_data  = '0;
    bus.irdy      = 2'b11;
    bus.ilck      = 2'b00;
    step();
    step();
    chk("rst_ovalid",    64'(bus.ovalid),    64'd0);
    chk("rst_odata",     bus.odata,          64'd0);
    chk("rst_ovch",      64'(bus.ovch),      64'd0);
    chk("rst_pkt_ready", 64'(bus.pkt_ready), 64'd1);
    chk("rst_pay_ready", 64'(bus.pay_ready), 64'd0);
    chk("rst_busy",      64'(busy),          64'd0);
    chk("rst_tx_pkts",   64'(tx_pkts),       64'd0);
    rst_ = 1'b0;
    step();

    // Single HEADTAIL flit
    send_desc(4'd5, 4'd0);
    chk("vcsel_busy",      64'(busy),          64'd1);
    chk("vcsel_pkt_ready", 64'(bus.pkt_ready), 64'd0);
    step();
    chk("head_wait_ovalid", 64'(bus.ovalid), 64'd0);
    step();
    chk("ht_ovalid",  64'(bus.ovalid), 64'd1);
    chk("ht_odata",   bus.odata,       64'h8A40_0000_0000_0000);
    chk("ht_odata_f", bus.odata,       mk_head(3'd4, 4'd5, 4'd2, 1'b0));
    chk("ht_ovch",    64'(bus.ovch),   64'd0);
    chk("ht_tx_pkts", 64'(tx_pkts),    64'd1);
    chk("ht_busy",    64'(busy),       64'd0);
    step();
    chk("idle_ovalid", 64'(bus.ovalid), 64'd0);
    chk("idle_odata",  bus.odata,       64'd0);

    // len=3 continuous payload; rr_ptr is 1 so VC1 is used
    bus.pay_valid = 1'b1;
    bus.pay_data  = 61'hA;
    send_desc(4'd7, 4'd3);
    step();
    step();
    chk("p3_head",      bus.odata,          mk_head(3'd1, 4'd7, 4'd2, 1'b1));
    chk("p3_head_ovch", 64'(bus.ovch),      64'd1);
    chk("p3_pay_ready", 64'(bus.pay_ready), 64'd1);
    step();
    chk("p3_b0",      bus.odata,     mk_pay(3'd2, 61'hA));
    chk("p3_b0_ovch", 64'(bus.ovch), 64'd1);
    bus.pay_data = 61'hB;
    step();
    chk("p3_b1", bus.odata, mk_pay(3'd2, 61'hB));
    bus.pay_data = 61'hC;
    step();
    chk("p3_tail",      bus.odata,     mk_pay(3'd3, 61'hC));
    chk("p3_tail_ovch", 64'(bus.ovch), 64'd1);
    chk("p3_tx_pkts",   64'(tx_pkts),  64'd2);
    bus.pay_valid = 1'b0;
    step();
    chk("p3_after_ovalid", 64'(bus.ovalid), 64'd0);

    // VC0 locked -> VC1; then unlocked, rr_ptr wrapped to 0 -> VC0
    bus.ilck = 2'b01;
    send_desc(4'd3, 4'd0);
    step();
    step();
    chk("lck_head", bus.odata,     mk_head(3'd4, 4'd3, 4'd2, 1'b1));
    chk("lck_ovch", 64'(bus.ovch), 64'd1);
    bus.ilck = 2'b00;
    send_desc(4'd4, 4'd0);
    step();
    step();
    chk("rr_head",    bus.odata,     mk_head(3'd4, 4'd4, 4'd2, 1'b0));
    chk("rr_ovch",    64'(bus.ovch), 64'd0);
    chk("rr_tx_pkts", 64'(tx_pkts),  64'd4);

    // irdy on the packet's VC dropped for two cycles mid-body
    bus.pay_valid = 1'b1;
    bus.pay_data  = 61'h1;
    send_desc(4'd6, 4'd3);
    step();
    step();
    chk("bp_head", bus.odata, mk_head(3'd1, 4'd6, 4'd2, 1'b1));
    step();
    chk("bp_b0", bus.odata, mk_pay(3'd2, 61'h1));
    bus.irdy     = 2'b01;
    bus.pay_data = 61'h2;
    #1;
    chk("bp_pay_ready_lo", 64'(bus.pay_ready), 64'd0);
    step();
    chk("bp_gap0", 64'(bus.ovalid), 64'd0);
    step();
    chk("bp_gap1",    64'(bus.ovalid),    64'd0);
    chk("bp_gap_rdy", 64'(bus.pay_ready), 64'd0);
    bus.irdy = 2'b11;
    step();
    chk("bp_b1",      bus.odata,      mk_pay(3'd2, 61'h2));
    chk("bp_b1_vld",  64'(bus.ovalid), 64'd1);
    bus.pay_data = 61'h3;
    step();
    chk("bp_tail",    bus.odata,     mk_pay(3'd3, 61'h3));
    chk("bp_tx_pkts", 64'(tx_pkts),  64'd5);
    bus.pay_valid = 1'b0;
    step();

    // Reset right after the head of a len=4 packet
    send_desc(4'd9, 4'd4);
    step();
    step();
    chk("ab_head", bus.odata, mk_head(3'd1, 4'd9, 4'd2, 1'b0));
    rst_ = 1'b1;
    #1;
    chk("ab_ovalid",    64'(bus.ovalid),    64'd0);
    chk("ab_odata",     bus.odata,          64'd0);
    chk("ab_pkt_ready", 64'(bus.pkt_ready), 64'd1);
    chk("ab_tx_pkts",   64'(tx_pkts),       64'd0);
    chk("ab_busy",      64'(busy),          64'd0);
    step();
    rst_ = 1'b0;
    step();
    chk("ab_idle_ovalid", 64'(bus.ovalid), 64'd0);

    // Counter preset to 0xFFFF; next packet wraps it. rr_ptr restarted at 0 -> VC0.
    force dut.tx_pkts = 16'hFFFF;
    step();
    release dut.tx_pkts;
    send_desc(4'd1, 4'd0);
    step();
    step();
    chk("wrap_head",    bus.odata,     mk_head(3'd4, 4'd1, 4'd2, 1'b0));
    chk("wrap_ovch",    64'(bus.ovch), 64'd0);
    chk("wrap_tx_pkts", 64'(tx_pkts),  64'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ni_tx.md
# ni_tx

Network-interface injector: the transmitter that drives a router input channel's link (data, valid, VC id) from a local core. Accepts one packet descriptor plus a payload stream, builds the head flit (dst, src = my_id, VC), emits body/tail flits, and obeys the router's per-VC ready and lock feedback. It sits between a core's send port and router port 4 (local), one instance per node.

## Interface
- DATAW, 64, flit width including type field
- NODEW, 4, node-id width
- NVCH, 2, virtual channels on the link
- LENW, 4, payload-length width (0..15 payload flits)
- clk  in  1  clock, all state on rising edge
- rst_  in  1  reset, asynchronous, active-high
- my_id  in  NODEW  this node's id, written into head SRC field
- pkt_valid  in  1  packet descriptor valid
- pkt_ready  out  1  descriptor accepted when pkt_valid && pkt_ready
- pkt_dst  in  NODEW  destination node
- pkt_len  in  LENW  payload flit count; 0 = single HEADTAIL flit
- pay_valid  in  1  payload word valid
- pay_ready  out  1  payload word consumed when pay_valid && pay_ready
- pay_data  in  DATAW-3  payload bits (type field appended by this block)
- odata  out  DATAW  flit to router input channel
- ovalid  out  1  flit valid, one flit per cycle max
- ovch  out  log2(NVCH)  VC the flit is written into
- irdy  in  NVCH  per-VC buffer ready from router
- ilck  in  NVCH  per-VC lock (VC held by a packet in the router)
- busy  out  1  packet in progress
- tx_pkts  out  16  count of completed packets

## Operation
- FSM states: IDLE, VCSEL, HEAD, BODY.
- IDLE: pkt_ready=1. On handshake latch dst, len into regs; -> VCSEL.
- VCSEL: choose first VC with ilck=0 and irdy=1, round-robin from rr_ptr (pointer starts 0, advances to chosen+1 mod NVCH after each head). None eligible -> stay. Chosen -> latch cur_vc; -> HEAD.
- HEAD: when irdy[cur_vc]=1 register head flit: type = HEADTAIL if len=0 else HEAD; DST=dst, SRC=my_id, VCH=cur_vc. len=0 -> IDLE (tx_pkts++); else remaining=len -> BODY.
- BODY: pay_ready = irdy[cur_vc]. On payload handshake register flit {type, pay_data}; type = TAIL when remaining=1 else BODY; remaining--. Tail -> IDLE, tx_pkts++.
- Packet never changes VC after head; ilck is sampled only in VCSEL.
- irdy[cur_vc] low: no flit issued, ovalid=0 next cycle, state held; pay_ready=0.
- pay_valid low in BODY: bubble, ovalid=0.
- Idle link: odata=0, ovalid=0, ovch=0 (TYPE_NONE never sent with ovalid=1).
- tx_pkts wraps 0xFFFF -> 0.
- busy = state != IDLE.

## Timing
- Reset: state IDLE, odata=0, ovalid=0, ovch=0, pkt_ready=1 (comb from IDLE), pay_ready=0, busy=0, tx_pkts=0, rr_ptr=0.
- odata/ovalid/ovch registered; flit appears the cycle after its issue decision.
- Best case: descriptor accept at cycle T, VCSEL T+1, head issued T+2 (on link T+3), body k on link T+3+k.
- Sustained rate: 1 flit/cycle while irdy and pay_valid high.
- irdy is level-based with ≥1 slot headroom; a flit issued with irdy=1 is always accepted even if irdy falls the next cycle.
- Reset mid-packet: aborts, outputs to reset values immediately; partial packet is not resumed.

## Structure
- Shared package/define.h: flit type codes (TYPE_NONE, TYPE_HEAD, TYPE_BODY, TYPE_TAIL, TYPE_HEADTAIL), TYPE/DST/SRC/VCH field MSB/LSB constants, Enable/Disable; same ones the router input channel decodes.
- One sub-module: ni_vcsel (round-robin free-VC picker: ilck, irdy, rr_ptr -> grant, valid).

## Test plan
- Reset then pkt_dst=5, pkt_len=0, my_id=2, all irdy=1, ilck=0 -> one HEADTAIL flit, DST=5, SRC=2, ovch=0, tx_pkts=1.
- pkt_len=3, payload 0xA,0xB,0xC continuous -> HEAD, BODY(0xA), BODY(0xB), TAIL(0xC) on consecutive cycles, same ovch.
- ilck=2'b01 -> packet uses VC1; then ilck=0, second packet uses VC0 (rr_ptr wrapped).
- irdy[cur_vc] dropped 2 cycles mid-body -> pay_ready=0, two-cycle ovalid gap, no flit lost or duplicated.
- rst_ pulsed after head of len=4 packet -> ovalid=0 at once, pkt_ready=1, tx_pkts=0.
- tx_pkts preset by 65535 packets -> next packet wraps to 0.
